// File: rtl/spi_master_mc_if.sv
// Command, configuration and response handshake between the bridge front end
// and the SPI master engine.
interface spi_master_mc_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CS_W   = 2,
    parameter int unsigned DIV_W  = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_data;
    logic [CS_W-1:0]   cmd_cs;
    logic              cmd_last;
    logic              cfg_cpol;
    logic              cfg_cpha;
    logic [DIV_W-1:0]  cfg_div;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_data, cmd_cs, cmd_last, cfg_cpol, cfg_cpha, cfg_div, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_cs, cmd_last, cfg_cpol, cfg_cpha, cfg_div, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/spi_master_mc.sv
// Multi-chip-select SPI master: one full-duplex DATA_W-bit word per command, any SPI mode,
// runtime SCK divider, chip select optionally held across multi-word bursts.
module spi_master_mc #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CS = 4,
    parameter int unsigned DIV_W  = 8,
    localparam int unsigned CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    spi_master_mc_if.slave    bus,
    output logic              busy,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [NUM_CS-1:0] spi_cs_n
);
    localparam int unsigned NEDGE  = 2 * DATA_W;
    localparam int unsigned EDGE_W = $clog2(NEDGE + 1);

    typedef enum logic [2:0] {StIdle, StSwitch, StSetup, StShift, StHold, StResp} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] tx_q, rx_q;
    logic [CS_W-1:0]   cs_q;
    logic              last_q, cpha_q, err_q, held_q, sck_q, mosi_q;
    logic [DIV_W-1:0]  div_q, cnt_q;
    logic [EDGE_W-1:0] edge_q;
    logic [NUM_CS-1:0] cs_n_q;

    logic              accept, tick, cmd_bad, same_cs, last_edge;
    logic [DIV_W-1:0]  cmd_div;

    // Out-of-range indices decode to all selects inactive.
    function automatic logic [NUM_CS-1:0] sel_n(input logic [CS_W-1:0] idx);
        logic [NUM_CS-1:0] v;
        v = '1;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            if (32'(idx) == i) v[i] = 1'b0;
        end
        return v;
    endfunction

    assign accept    = bus.cmd_valid && bus.cmd_ready;
    assign cmd_bad   = 32'(bus.cmd_cs) >= NUM_CS;
    assign same_cs   = held_q && (bus.cmd_cs == cs_q);
    assign cmd_div   = (bus.cfg_div == '0) ? DIV_W'(1) : bus.cfg_div;
    assign tick      = (cnt_q == '0);
    assign last_edge = (edge_q == EDGE_W'(NEDGE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (same_cs)     state_d = StShift;
                    else if (held_q) state_d = StSwitch;
                    else             state_d = StSetup;
                end
            end
            StSwitch: if (tick) state_d = StSetup;
            // The lead-time tick doubles as the first SCK edge.
            StSetup:  if (tick) state_d = StShift;
            StShift:  if (tick && last_edge) state_d = StHold;
            StHold:   if (!last_q || tick) state_d = StResp;
            StResp:   if (bus.rsp_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.cmd_ready = (state_q == StIdle) && !rst;
        bus.rsp_valid = (state_q == StResp);
        bus.rsp_data  = rx_q;
        bus.rsp_err   = (state_q == StResp) && err_q;
        busy          = (state_q != StIdle) || held_q;
        spi_sck       = sck_q;
        spi_mosi      = mosi_q;
        spi_cs_n      = cs_n_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q   <= '0;
            rx_q   <= '0;
            cs_q   <= '0;
            last_q <= 1'b0;
            cpha_q <= 1'b0;
            err_q  <= 1'b0;
            held_q <= 1'b0;
            sck_q  <= 1'b0;
            mosi_q <= 1'b0;
            div_q  <= DIV_W'(1);
            cnt_q  <= '0;
            edge_q <= '0;
            cs_n_q <= '1;
        end else begin
            if (state_q inside {StSwitch, StSetup, StShift, StHold}) begin
                cnt_q <= tick ? div_q - DIV_W'(1) : cnt_q - DIV_W'(1);
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        tx_q   <= bus.cmd_data;
                        cs_q   <= bus.cmd_cs;
                        last_q <= bus.cmd_last;
                        cpha_q <= bus.cfg_cpha;
                        div_q  <= cmd_div;
                        cnt_q  <= cmd_div - DIV_W'(1);
                        edge_q <= '0;
                        err_q  <= cmd_bad;
                        sck_q  <= bus.cfg_cpol;
                        if (!bus.cfg_cpha) mosi_q <= bus.cmd_data[DATA_W-1];
                        if (held_q && !same_cs) begin
                            cs_n_q <= '1;
                            held_q <= 1'b0;
                        end else if (!held_q) begin
                            cs_n_q <= sel_n(bus.cmd_cs);
                            held_q <= !cmd_bad;
                        end
                    end
                end
                StSwitch: begin
                    if (tick) begin
                        cs_n_q <= sel_n(cs_q);
                        held_q <= !err_q;
                    end
                end
                StSetup, StShift: begin
                    if (tick) begin
                        sck_q  <= ~sck_q;
                        edge_q <= edge_q + EDGE_W'(1);
                        // edge_q[0]==0 is a leading edge; cpha picks which parity samples.
                        if (edge_q[0] == cpha_q) begin
                            rx_q <= {rx_q[DATA_W-2:0], spi_miso};
                        end else if (cpha_q) begin
                            mosi_q <= tx_q[DATA_W-1];
                            tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
                        end else if (!last_edge) begin
                            mosi_q <= tx_q[DATA_W-2];
                            tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                StHold: begin
                    if (tick && last_q) begin
                        cs_n_q <= '1;
                        held_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_mc.sv
// Randomised and directed bench for spi_master_mc with a behavioural SPI slave
// and a transaction-level timing model.
module tb_spi_master_mc;
    localparam int unsigned DW    = 8;
    localparam int unsigned NCS   = 5;  // five selects so a 3-bit index can name invalid targets
    localparam int unsigned CSW   = 3;
    localparam int unsigned DVW   = 8;
    localparam int unsigned NEDGE = 2 * DW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           busy, spi_sck, spi_mosi, spi_miso;
    logic [NCS-1:0] spi_cs_n;

    spi_master_mc_if #(.DATA_W(DW), .CS_W(CSW), .DIV_W(DVW)) bus ();

    spi_master_mc #(.DATA_W(DW), .NUM_CS(NCS), .DIV_W(DVW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_cs_n (spi_cs_n)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit held     = 1'b0;  // a non-last word left its select asserted
    int held_idx = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One command through to its response. kind: 0 fresh select, 1 same held select, 2 switch.
    task automatic xfer(input logic [DW-1:0] data, input int cs, input bit last, input bit cpol,
                        input bit cpha, input int div, input logic [DW-1:0] slave,
                        input bit loopback, input int stall, input bit early);
        int             d, k, kind, edges, samples, first_edge, last_edge;
        int             bad_gap, bad_cs, two_low, cs_low, rsp_k, unstable;
        logic [NCS-1:0] pat, all1, cs1;
        logic [DW-1:0]  mosi_w, rsp_d;
        logic           rsp_e, prev_sck, sck1;
        d     = (div == 0) ? 1 : div;
        all1  = '1;
        pat   = '1;
        if (cs < NCS) pat[cs] = 1'b0;
        kind  = !held ? 0 : (cs == held_idx) ? 1 : 2;
        edges = 0; samples = 0; first_edge = 0; last_edge = 0;
        bad_gap = 0; bad_cs = 0; two_low = 0; cs_low = 0; rsp_k = 0;
        mosi_w = '0; cs1 = '0; sck1 = 1'b0; prev_sck = 1'b0;

        k = 0;
        while (bus.cmd_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("cmd_ready_idle", 32'(bus.cmd_ready), 1);
        bus.cmd_data  = data;
        bus.cmd_cs    = CSW'(cs);
        bus.cmd_last  = last;
        bus.cfg_cpol  = cpol;
        bus.cfg_cpha  = cpha;
        bus.cfg_div   = DVW'(div);
        bus.cmd_valid = 1'b1;
        bus.rsp_ready = early;
        spi_miso      = loopback ? spi_mosi : slave[DW-1];
        @(posedge clk);

        for (k = 1; k <= 3000; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.cmd_valid = 1'b0;
                // Config must be ignored once the command is taken.
                bus.cmd_data  = DW'($urandom);
                bus.cfg_cpol  = 1'($urandom);
                bus.cfg_cpha  = 1'($urandom);
                bus.cfg_div   = DVW'($urandom);
                sck1          = spi_sck;
                cs1           = spi_cs_n;
                prev_sck      = spi_sck;
            end else if (spi_sck !== prev_sck) begin
                prev_sck = spi_sck;
                edges++;
                if (edges == 1) first_edge = k;
                else if (k - last_edge != d) bad_gap++;
                last_edge = k;
                if (spi_cs_n !== pat) bad_cs++;
                if (((edges % 2) == 1) != cpha) begin
                    mosi_w = {mosi_w[DW-2:0], spi_mosi};
                    samples++;
                    if (samples < DW) spi_miso = slave[DW-1-samples];
                end
            end
            if (loopback) spi_miso = spi_mosi;
            if ($countones(~spi_cs_n) > 1) two_low++;
            if (cs_low == 0 && pat != all1 && spi_cs_n === pat) cs_low = k;
            if (bus.rsp_valid === 1'b1) begin
                rsp_k = k;
                break;
            end
        end

        if (rsp_k == 0) begin
            check("rsp_timeout", 0, 1);
            return;
        end
        check("edge_count", edges, NEDGE);
        check("edge_gap", bad_gap, 0);
        if (kind != 1) check("first_edge", first_edge, (kind == 2) ? 1 + 2 * d : 1 + d);
        check("sck_idle", 32'(sck1), 32'(cpol));
        check("cs_cycle1", 32'(cs1), 32'((kind == 2) ? all1 : pat));
        if (pat != all1) check("cs_low_at", cs_low, (kind == 2) ? 1 + d : 1);
        check("cs_at_edges", bad_cs, 0);
        check("one_cs_low", two_low, 0);
        check("mosi_word", 32'(mosi_w), 32'(data));
        check("rsp_data", 32'(bus.rsp_data), 32'(loopback ? data : slave));
        check("rsp_err", 32'(bus.rsp_err), 32'(cs >= NCS));
        check("rsp_at", rsp_k, last ? last_edge + d : last_edge + 1);
        check("cs_at_rsp", 32'(spi_cs_n), 32'(last ? all1 : pat));
        check("sck_rest", 32'(spi_sck), 32'(cpol));
        check("ready_blocked", 32'(bus.cmd_ready), 0);

        rsp_d = bus.rsp_data;
        rsp_e = bus.rsp_err;
        unstable = 0;
        if (!early) begin
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== rsp_d || bus.rsp_err !== rsp_e ||
                    bus.cmd_ready !== 1'b0) unstable++;
            end
            if (stall > 0) check("rsp_stable", unstable, 0);
            bus.rsp_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("rsp_cleared", 32'(bus.rsp_valid), 0);
        check("ready_back", 32'(bus.cmd_ready), 1);
        held     = !last && (cs < NCS);
        held_idx = cs;
        check("busy_after", 32'(busy), 32'(held));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        bus.cmd_cs    = '0;
        bus.cmd_last  = 1'b0;
        bus.cfg_cpol  = 1'b0;
        bus.cfg_cpha  = 1'b0;
        bus.cfg_div   = '0;
        bus.rsp_ready = 1'b0;
        spi_miso      = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.cmd_ready), 0);
        check("rst_cs_n", 32'(spi_cs_n), 32'({NCS{1'b1}}));
        check("rst_pins", {spi_sck, spi_mosi, busy}, 0);
        check("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.cmd_ready), 1);

        // Directed cases
        xfer(8'hA5, 1, 1'b1, 1'b0, 1'b0, 2, 8'h3C, 1'b0, 0, 1'b0);
        xfer(8'h81, 0, 1'b1, 1'b1, 1'b1, 1, 8'h00, 1'b1, 0, 1'b0);
        xfer(8'h12, 2, 1'b0, 1'b0, 1'b0, 3, 8'h5A, 1'b0, 0, 1'b0);
        xfer(8'h34, 2, 1'b1, 1'b0, 1'b0, 3, 8'hC3, 1'b0, 0, 1'b0);
        xfer(8'h55, 0, 1'b0, 1'b0, 1'b1, 2, 8'h96, 1'b0, 0, 1'b0);
        xfer(8'hAA, 3, 1'b1, 1'b1, 1'b0, 2, 8'h69, 1'b0, 0, 1'b0);
        xfer(8'h6E, 5, 1'b1, 1'b0, 1'b0, 0, 8'h99, 1'b0, 0, 1'b0);
        xfer(8'hF0, 4, 1'b1, 1'b1, 1'b0, 1, 8'h0F, 1'b0, 20, 1'b0);
        xfer(8'h3D, 1, 1'b0, 1'b0, 1'b1, 2, 8'hE2, 1'b0, 0, 1'b1);
        xfer(8'hC4, 6, 1'b1, 1'b0, 1'b0, 1, 8'h1B, 1'b0, 0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            xfer(DW'($urandom), int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                 1'($urandom), int'($urandom_range(0, 4)), DW'($urandom), 1'($urandom_range(0, 5) == 0),
                 int'($urandom_range(0, 3)), 1'($urandom));
        end

        // Reset in the middle of a mode-3 transfer, SCK high and MOSI high.
        @(negedge clk);
        bus.cmd_data  = 8'h80;
        bus.cmd_cs    = 3'd4;
        bus.cmd_last  = 1'b1;
        bus.cfg_cpol  = 1'b1;
        bus.cfg_cpha  = 1'b1;
        bus.cfg_div   = 8'd3;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_rst_pins", {spi_sck, spi_mosi, spi_cs_n}, {2'b11, 5'b01111});
        rst = 1'b1;
        #1;
        check("mid_rst_cs_n", 32'(spi_cs_n), 32'({NCS{1'b1}}));
        check("mid_rst_pins", {spi_sck, spi_mosi, bus.cmd_ready, bus.rsp_valid, busy}, 0);
        @(negedge clk);
        rst  = 1'b0;
        held = 1'b0;
        @(negedge clk);
        check("mid_rst_recover", {bus.cmd_ready, busy, bus.rsp_data}, {1'b1, 1'b0, 8'h00});
        xfer(8'h5C, 2, 1'b1, 1'b0, 1'b1, 2, 8'hB7, 1'b0, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
